// File: rtl/kmem_bank_router_if.sv
// Avalon-MM signal bundle between the kernel interconnect, kmem_bank_router and the per-bank EMIFs.
// slave: router view. master: environment view (kernel plus EMIFs).
interface kmem_bank_router_if #(
  parameter int NUM_BANKS = 2,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 5
);
  // Handshake: a command transfers on a clock edge where read or write is high and the
  // matching waitrequest is low; readdatavalid qualifies readdata for exactly one cycle
  // and cannot be back-pressured.
  logic [ADDR_W-1:0]             kernel_mem_address;
  logic                          kernel_mem_read;
  logic                          kernel_mem_write;
  logic [BURST_W-1:0]            kernel_mem_burstcount;
  logic [DATA_W-1:0]             kernel_mem_writedata;
  logic [DATA_W/8-1:0]           kernel_mem_byteenable;
  logic                          kernel_mem_waitrequest;
  logic [DATA_W-1:0]             kernel_mem_readdata;
  logic                          kernel_mem_readdatavalid;
  logic [NUM_BANKS*ADDR_W-1:0]   emif_address;
  logic [NUM_BANKS-1:0]          emif_read;
  logic [NUM_BANKS-1:0]          emif_write;
  logic [NUM_BANKS*BURST_W-1:0]  emif_burstcount;
  logic [NUM_BANKS*DATA_W-1:0]   emif_writedata;
  logic [NUM_BANKS*DATA_W/8-1:0] emif_byteenable;
  logic [NUM_BANKS-1:0]          emif_waitrequest;
  logic [NUM_BANKS*DATA_W-1:0]   emif_readdata;
  logic [NUM_BANKS-1:0]          emif_readdatavalid;

  modport slave (
    input  kernel_mem_address, kernel_mem_read, kernel_mem_write, kernel_mem_burstcount,
    input  kernel_mem_writedata, kernel_mem_byteenable,
    output kernel_mem_waitrequest, kernel_mem_readdata, kernel_mem_readdatavalid,
    output emif_address, emif_read, emif_write, emif_burstcount, emif_writedata, emif_byteenable,
    input  emif_waitrequest, emif_readdata, emif_readdatavalid
  );

  modport master (
    output kernel_mem_address, kernel_mem_read, kernel_mem_write, kernel_mem_burstcount,
    output kernel_mem_writedata, kernel_mem_byteenable,
    input  kernel_mem_waitrequest, kernel_mem_readdata, kernel_mem_readdatavalid,
    input  emif_address, emif_read, emif_write, emif_burstcount, emif_writedata, emif_byteenable,
    output emif_waitrequest, emif_readdata, emif_readdatavalid
  );
endinterface

// File: rtl/kmem_bank_router.sv
// Address-interleaving router from one kernel Avalon-MM port to NUM_BANKS EMIF ports with in-order reads.
// Optional per-bank performance counters are built when KMEM_BANK_ROUTER_PERF_EN is defined.
module kmem_bank_router #(
  parameter int NUM_BANKS = 2,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 5,
  parameter int INTLV_LSB = 10,
  parameter int RSP_DEPTH = 64
) (
  input  logic                    kernel_clk_clk,
  input  logic                    kernel_reset_reset_n,
  kmem_bank_router_if.slave       bus,
`ifdef KMEM_BANK_ROUTER_PERF_EN
  input  logic                    perf_clear,
  output logic [NUM_BANKS*32-1:0] perf_rd_beats,
  output logic [NUM_BANKS*32-1:0] perf_wr_beats,
  output logic [NUM_BANKS*32-1:0] perf_stall_cycles,
`endif
  output logic                    wr_fsm_state
);
  localparam int BS   = $clog2(NUM_BANKS);
  localparam int SW   = (BS == 0) ? 1 : BS;
  localparam int PW   = $clog2(RSP_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << INTLV_LSB) - ADDR_W'(1);

  typedef enum logic {IDLE = 1'b0, WBURST = 1'b1} wr_state_e;

  wr_state_e          state;
  logic [SW-1:0]      wr_bank;
  logic [BURST_W-1:0] wr_left;
  logic               live;

  logic [SW-1:0]      tag_bank [RSP_DEPTH];
  logic [BURST_W-1:0] tag_len  [RSP_DEPTH];
  logic [PW-1:0]      tag_wp, tag_rp;
  logic [CW-1:0]      tag_cnt;
  logic [BURST_W-1:0] head_done;

  logic [DATA_W-1:0]  rsp_mem [NUM_BANKS][RSP_DEPTH];
  logic [PW-1:0]      rsp_wp  [NUM_BANKS];
  logic [PW-1:0]      rsp_rp  [NUM_BANKS];
  logic [CW-1:0]      rsp_cnt [NUM_BANKS];
  logic [CW-1:0]      out_cnt [NUM_BANKS];

  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q;

  logic [SW-1:0]      addr_sel, cmd_sel, head_bank;
  logic [ADDR_W-1:0]  bank_addr;
  logic [CW:0]        credit_need;
  logic               rd_stall, wait_int, rd_acc, wr_acc, pop, tag_pop;
  logic [NUM_BANKS-1:0] rsp_push, rsp_pop;

  // Bank bits are cut out of the address; everything above them slides down.
  assign addr_sel  = SW'((bus.kernel_mem_address >> INTLV_LSB) & ADDR_W'(NUM_BANKS - 1));
  assign bank_addr = ((bus.kernel_mem_address >> (INTLV_LSB + BS)) << INTLV_LSB)
                   | (bus.kernel_mem_address & LOW_MASK);
  assign cmd_sel   = (state == WBURST) ? wr_bank : addr_sel;

  assign credit_need = {1'b0, out_cnt[cmd_sel]} + (CW+1)'(bus.kernel_mem_burstcount);
  assign rd_stall    = bus.kernel_mem_read &&
                       ((state == WBURST) || (credit_need > (CW+1)'(RSP_DEPTH)) ||
                        (tag_cnt == CW'(RSP_DEPTH)));
  assign wait_int    = !kernel_reset_reset_n || !live || bus.emif_waitrequest[cmd_sel] || rd_stall;
  assign rd_acc      = bus.kernel_mem_read  && !wait_int;
  assign wr_acc      = bus.kernel_mem_write && !wait_int;

  assign head_bank = tag_bank[tag_rp];
  assign pop       = live && (tag_cnt != '0) && (rsp_cnt[head_bank] != '0);
  assign tag_pop   = pop && ((head_done + BURST_W'(1)) == tag_len[tag_rp]);

  assign bus.kernel_mem_waitrequest   = wait_int;
  assign bus.kernel_mem_readdata      = rdata_q;
  assign bus.kernel_mem_readdatavalid = rvalid_q;
  assign wr_fsm_state                 = (state == WBURST);

  always_comb begin
    bus.emif_read  = '0;
    bus.emif_write = '0;
    rsp_push       = '0;
    rsp_pop        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.emif_address[b*ADDR_W +: ADDR_W]       = bank_addr;
      bus.emif_burstcount[b*BURST_W +: BURST_W]  = bus.kernel_mem_burstcount;
      bus.emif_writedata[b*DATA_W +: DATA_W]     = bus.kernel_mem_writedata;
      bus.emif_byteenable[b*DATA_W/8 +: DATA_W/8] = bus.kernel_mem_byteenable;
      if (kernel_reset_reset_n && live && cmd_sel == SW'(b)) begin
        bus.emif_read[b]  = bus.kernel_mem_read && !rd_stall;
        bus.emif_write[b] = bus.kernel_mem_write;
      end
      rsp_push[b] = live && bus.emif_readdatavalid[b];
      rsp_pop[b]  = pop && (head_bank == SW'(b));
    end
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (rd_acc) begin
      tag_bank[tag_wp] <= cmd_sel;
      tag_len[tag_wp]  <= bus.kernel_mem_burstcount;
    end
    for (int b = 0; b < NUM_BANKS; b++)
      if (rsp_push[b]) rsp_mem[b][rsp_wp[b]] <= bus.emif_readdata[b*DATA_W +: DATA_W];
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (!kernel_reset_reset_n) begin
      live      <= 1'b0;
      state     <= IDLE;
      wr_bank   <= '0;
      wr_left   <= '0;
      tag_wp    <= '0;
      tag_rp    <= '0;
      tag_cnt   <= '0;
      head_done <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rsp_wp[b]  <= '0;
        rsp_rp[b]  <= '0;
        rsp_cnt[b] <= '0;
        out_cnt[b] <= '0;
      end
    end else begin
      // live stays low for the first cycle after release so stale EMIF beats are dropped.
      live <= 1'b1;
      if (wr_acc) begin
        case (state)
          IDLE: if (bus.kernel_mem_burstcount > BURST_W'(1)) begin
            state   <= WBURST;
            wr_bank <= addr_sel;
            wr_left <= bus.kernel_mem_burstcount - BURST_W'(1);
          end
          WBURST: begin
            wr_left <= wr_left - BURST_W'(1);
            if (wr_left == BURST_W'(1)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (rd_acc) tag_wp <= tag_wp + PW'(1);
      if (tag_pop) tag_rp <= tag_rp + PW'(1);
      tag_cnt <= tag_cnt + CW'(rd_acc) - CW'(tag_pop);
      if (pop) begin
        head_done <= tag_pop ? '0 : head_done + BURST_W'(1);
        rdata_q   <= rsp_mem[head_bank][rsp_rp[head_bank]];
      end
      rvalid_q <= pop;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rsp_push[b]) rsp_wp[b] <= rsp_wp[b] + PW'(1);
        if (rsp_pop[b])  rsp_rp[b] <= rsp_rp[b] + PW'(1);
        rsp_cnt[b] <= rsp_cnt[b] + CW'(rsp_push[b]) - CW'(rsp_pop[b]);
        out_cnt[b] <= out_cnt[b]
                    + ((rd_acc && cmd_sel == SW'(b)) ? CW'(bus.kernel_mem_burstcount) : CW'(0))
                    - CW'(rsp_pop[b]);
      end
    end
  end

`ifdef KMEM_BANK_ROUTER_PERF_EN
  logic [31:0] cnt_rd [NUM_BANKS];
  logic [31:0] cnt_wr [NUM_BANKS];
  logic [31:0] cnt_st [NUM_BANKS];

  always_ff @(posedge kernel_clk_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!kernel_reset_reset_n || perf_clear) begin
        cnt_rd[b] <= '0;
        cnt_wr[b] <= '0;
        cnt_st[b] <= '0;
      end else begin
        if (rsp_pop[b] && cnt_rd[b] != '1) cnt_rd[b] <= cnt_rd[b] + 32'd1;
        if (wr_acc && cmd_sel == SW'(b) && cnt_wr[b] != '1) cnt_wr[b] <= cnt_wr[b] + 32'd1;
        if ((bus.kernel_mem_read || bus.kernel_mem_write) && wait_int &&
            cmd_sel == SW'(b) && cnt_st[b] != '1)
          cnt_st[b] <= cnt_st[b] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_perf
    assign perf_rd_beats[g*32 +: 32]     = cnt_rd[g];
    assign perf_wr_beats[g*32 +: 32]     = cnt_wr[g];
    assign perf_stall_cycles[g*32 +: 32] = cnt_st[g];
  end
`endif
endmodule

// File: doc/kmem_bank_router.md
Name: kmem_bank_router

Overview:
- Parametrised router between one kernel-side Avalon-MM slave port and NUM_BANKS EMIF-side Avalon-MM master ports.
- Sits in the board system between the kernel global-memory interconnect and the per-bank DDR4 EMIFs.
- Interleaves the address space across the banks.
- Buffers read responses per bank and returns them to the kernel strictly in request order.

Parameters:
- NUM_BANKS, 2, number of memory banks; power of 2, range 1..8.
- DATA_W, 512, data width in bits; byteenable width is DATA_W/8.
- ADDR_W, 32, byte address width on both sides.
- BURST_W, 5, burstcount width on both sides.
- INTLV_LSB, 10, lowest address bit used for bank select; 2^INTLV_LSB bytes must be ≥ (2^(BURST_W-1))·DATA_W/8.
- RSP_DEPTH, 64, per-bank response FIFO depth in beats; power of 2, ≥ 2^(BURST_W-1).

Ports:
- kernel_clk_clk  in  1  clock.
- kernel_reset_reset_n  in  1  reset; synchronous, active-low.
- kernel_mem_address  in  ADDR_W  byte address.
- kernel_mem_read / kernel_mem_write  in  1  commands.
- kernel_mem_burstcount  in  BURST_W  beats, 1..2^(BURST_W-1).
- kernel_mem_writedata  in  DATA_W.
- kernel_mem_byteenable  in  DATA_W/8.
- kernel_mem_waitrequest  out  1.
- kernel_mem_readdata  out  DATA_W.
- kernel_mem_readdatavalid  out  1.
- emif_address  out  NUM_BANKS·ADDR_W  per-bank byte address, bank b at slice b.
- emif_read / emif_write  out  NUM_BANKS.
- emif_burstcount  out  NUM_BANKS·BURST_W.
- emif_writedata  out  NUM_BANKS·DATA_W.
- emif_byteenable  out  NUM_BANKS·DATA_W/8.
- emif_waitrequest  in  NUM_BANKS.
- emif_readdata  in  NUM_BANKS·DATA_W.
- emif_readdatavalid  in  NUM_BANKS.

Behaviour:
- Bank select: B = log2(NUM_BANKS). sel = address[INTLV_LSB +: B]. Bank address = address with those B bits removed, upper bits shifted down, MSBs zero-filled. NUM_BANKS=1 makes this a pass-through.
- Command path is combinational. The selected bank receives address, burstcount, writedata, byteenable, read and write. All other banks see read=write=0.
- kernel_mem_waitrequest = emif_waitrequest[sel] OR read-credit stall OR reset.
- Write FSM, states IDLE and WBURST.
  - IDLE: an accepted write with burstcount=1 stays in IDLE.
  - IDLE: an accepted write with burstcount>1 latches sel and remaining count (burstcount-1), then moves to WBURST.
  - WBURST: routes to the latched bank, ignoring the address. Decrements per accepted beat. Returns to IDLE on the last beat.
  - A read presented during WBURST is held off with waitrequest=1.
- Read credit: each bank has an outstanding-beat counter of width log2(RSP_DEPTH)+1.
  - Read issue stalls while outstanding[sel] + burstcount > RSP_DEPTH.
  - The counter increments by burstcount on read accept and decrements by 1 when a beat leaves that bank's FIFO.
  - An increment and a decrement in the same cycle net together.
- Order tag FIFO: depth RSP_DEPTH, entry {bank, burstcount}, pushed on each accepted read.
  - Read issue also stalls when the tag FIFO is full.
- Response FIFOs: one per bank, each pushes unconditionally on emif_readdatavalid. Overflow cannot occur by construction; the bench asserts this.
- Return path:
  - The output pops the head-tag bank's FIFO when it is non-empty.
  - Output is registered: readdatavalid is asserted 1 cycle after the pop, so minimum EMIF-to-kernel latency is 1 cycle after the FIFO write.
  - The tag is popped when its beat count is exhausted.
  - Back-to-back bursts from different banks stream with no bubble.
- Simultaneous push and pop on an empty FIFO does not bypass; data appears the next cycle.
- Reset values: kernel_mem_waitrequest=1, kernel_mem_readdatavalid=0, kernel_mem_readdata=0, all emif_read/emif_write=0, all FIFOs empty, counters 0, FSM IDLE.
- Reset asserted mid-burst: all state is discarded. Responses arriving in the first cycle after reset release are dropped.

Optional Feature:
- Macro: KMEM_BANK_ROUTER_PERF_EN.
- When defined, adds perf_clear (in, 1) and the following outputs, each NUM_BANKS·32 bits wide:
  - perf_rd_beats: counts read beats returned per bank.
  - perf_wr_beats: counts write beats accepted per bank.
  - perf_stall_cycles: counts cycles with a command presented to the bank and waitrequest=1.
- Counters saturate at 2^32-1, clear synchronously on perf_clear or reset, and are readable directly.
- When not defined, these ports and counters do not exist.

Test Plan:
- NUM_BANKS=2, INTLV_LSB=10: write 0x0400 burst 4 → bank1 sees address 0x0000, burstcount 4, 4 beats. Bank0 idle.
- Read 0x0000 burst 2, then 0x0400 burst 2; bank1 responds before bank0 → kernel receives bank0 beats then bank1 beats, 4 consecutive valid cycles.
- RSP_DEPTH=64 with bank0 never responding: 4 reads burst 16 accepted, 5th stalls (waitrequest=1). After 1 beat drains, the 5th is still stalled. After 16 beats drain, it is accepted.
- emif_waitrequest[1]=1 during WBURST beat 2 of 4 → beat held. A read to bank0 presented concurrently stays waitrequested until the write burst completes.
- Reset mid read burst (2 of 8 beats returned) → readdatavalid=0 the next cycle, counters 0. A new read 0x0800 completes normally.
- With KMEM_BANK_ROUTER_PERF_EN: 10 write beats to bank0 and 6 read beats from bank1 → perf_wr_beats[0]=10, perf_rd_beats[1]=6. After perf_clear, all read 0.
